// File: rtl/vga_display.sv
// vga_display: pixel source for the 1280x1024@60 VGA path.
// Returns an 8-bar colour background with a bouncing 100x100 ROM image
// overlaid, one vga_clk after each pixel_xpos/pixel_ypos request.
module vga_display #(
   parameter int H_DISP = 1280,
   parameter int V_DISP = 1024,
   parameter int IMG_W  = 100,
   parameter int IMG_H  = 100,
   parameter int STEP   = 4,
   parameter int BAR_W  = 160
) (
   input  logic        vga_clk,
   input  logic        sys_rst,
   input  logic        move_en,
   input  logic [10:0] pixel_xpos,
   input  logic [10:0] pixel_ypos,
   output logic [23:0] pixel_data,
   output logic [13:0] rom_addr,
   input  logic [23:0] rom_q
);

   // Widths are fixed up front so every compare runs at 12 bits and
   // img_x + IMG_W can never wrap.
   localparam logic [11:0] IMG_W_12  = 12'(IMG_W);
   localparam logic [11:0] IMG_H_12  = 12'(IMG_H);
   localparam logic [11:0] STEP_12   = 12'(STEP);
   localparam logic [11:0] X_MAX_12  = 12'(H_DISP - IMG_W);
   localparam logic [11:0] Y_MAX_12  = 12'(V_DISP - IMG_H);
   localparam logic [13:0] IMG_W_14  = 14'(IMG_W);
   localparam logic [10:0] BAR_W_11  = 11'(BAR_W);
   localparam logic [10:0] X_LAST_11 = 11'(H_DISP - 1);
   localparam logic [10:0] Y_LAST_11 = 11'(V_DISP);

   // One motion axis: position plus direction (0 = towards MAX).
   typedef struct packed {
      logic        dir;
      logic [10:0] pos;
   } axis_t;

   // Bounce one axis by STEP, clamping at 0 / max_pos and flipping direction.
   function automatic axis_t step_axis(input axis_t cur, input logic [11:0] max_pos);
      axis_t       nxt;
      logic [11:0] pos_12;
      logic [11:0] fwd_12;
      logic [11:0] bwd_12;
      nxt    = cur;
      pos_12 = {1'b0, cur.pos};
      fwd_12 = pos_12 + STEP_12;
      bwd_12 = pos_12 - STEP_12;
      if (!cur.dir) begin
         if (fwd_12 >= max_pos) begin
            nxt.pos = max_pos[10:0];
            nxt.dir = 1'b1;
         end else begin
            nxt.pos = fwd_12[10:0];
         end
      end else begin
         if (pos_12 <= STEP_12) begin
            nxt.pos = '0;
            nxt.dir = 1'b0;
         end else begin
            nxt.pos = bwd_12[10:0];
         end
      end
      return nxt;
   endfunction

   axis_t       axis_x;
   axis_t       axis_y;

   logic        valid;
   logic        in_img;
   logic        frame_end;
   logic [11:0] xpos_12;
   logic [11:0] row_12;
   logic [11:0] img_x_12;
   logic [11:0] img_y_12;
   logic [11:0] dx_12;
   logic [11:0] dy_12;
   logic [13:0] addr_calc;
   logic [13:0] addr_hold;
   logic [10:0] bar_quot;
   logic [2:0]  bar;

   logic        valid_d;
   logic        in_img_d;
   logic [2:0]  bar_d;

   // Request decode for the current cycle.
   assign valid     = (pixel_ypos != 11'd0);
   assign xpos_12   = {1'b0, pixel_xpos};
   assign row_12    = {1'b0, pixel_ypos} - 12'd1;
   assign img_x_12  = {1'b0, axis_x.pos};
   assign img_y_12  = {1'b0, axis_y.pos};
   assign dx_12     = xpos_12 - img_x_12;
   assign dy_12     = row_12 - img_y_12;
   assign in_img    = valid
                      && (xpos_12 >= img_x_12) && (xpos_12 < img_x_12 + IMG_W_12)
                      && (row_12  >= img_y_12) && (row_12  < img_y_12 + IMG_H_12);
   assign addr_calc = 14'(dy_12) * IMG_W_14 + 14'(dx_12);
   assign bar_quot  = pixel_xpos / BAR_W_11;
   assign bar       = (bar_quot > 11'd7) ? 3'd7 : bar_quot[2:0];
   assign frame_end = (pixel_xpos == X_LAST_11) && (pixel_ypos == Y_LAST_11);

   // The ROM address follows the image while inside it and otherwise holds,
   // so the ROM does not toggle during background and blanking; reset forces 0.
   assign rom_addr  = sys_rst ? 14'd0 : (in_img ? addr_calc : addr_hold);

   // Capture the decode of this request for the output select next cycle.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         valid_d   <= 1'b0;
         in_img_d  <= 1'b0;
         bar_d     <= 3'd0;
         addr_hold <= 14'd0;
      end else begin
         valid_d   <= valid;
         in_img_d  <= in_img;
         bar_d     <= bar;
         if (in_img) begin
            addr_hold <= addr_calc;
         end
      end
   end

   // Move the image once per frame on the last request, so it never tears.
   always_ff @(posedge vga_clk or posedge sys_rst) begin
      if (sys_rst) begin
         axis_x <= '0;
         axis_y <= '0;
      end else if (frame_end && move_en) begin
         axis_x <= step_axis(axis_x, X_MAX_12);
         axis_y <= step_axis(axis_y, Y_MAX_12);
      end
   end

   // Output select: blank, ROM pixel, or the colour of the bar under the pixel.
   // NOTE: the output gets a default before any branch, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      pixel_data = 24'h000000;
      if (valid_d) begin
         if (in_img_d) begin
            pixel_data = rom_q;
         end else begin
            case (bar_d)
               3'd0:    pixel_data = 24'hFFFFFF;
               3'd1:    pixel_data = 24'h000000;
               3'd2:    pixel_data = 24'hFF0000;
               3'd3:    pixel_data = 24'h00FF00;
               3'd4:    pixel_data = 24'h0000FF;
               3'd5:    pixel_data = 24'hFFFF00;
               3'd6:    pixel_data = 24'h00FFFF;
               default: pixel_data = 24'hFF00FF;
            endcase
         end
      end
   end

endmodule

// File: doc/vga_display.md
# vga_display

Pixel source for the 1280x1024@60 VGA path. It sits directly upstream of the VGA timing driver: it takes the driver's `pixel_xpos`/`pixel_ypos` request coordinates and returns `pixel_data` one `vga_clk` later. The picture is an 8-bar colour background with a 100x100 image, read from an external synchronous ROM, overlaid on it. The image bounces around the screen, moving once per frame.

## Interface
Parameters:
- H_DISP, 1280: active pixels per line
- V_DISP, 1024: active lines per frame
- IMG_W, 100: image width in pixels
- IMG_H, 100: image height in lines
- STEP, 4: image displacement per frame on each axis, in pixels
- BAR_W, 160: colour bar width in pixels (H_DISP/8)

Ports (one clock; reset is asynchronous and active-high):
- vga_clk, input, 1: pixel clock
- sys_rst, input, 1: asynchronous, active-high reset
- move_en, input, 1: synchronous to vga_clk; 1 = image moves each frame, 0 = position frozen
- pixel_xpos, input, 11: requested column, 0..H_DISP-1
- pixel_ypos, input, 11: requested line, 1..V_DISP; 0 = no request (blanking)
- pixel_data, output, 24: RGB888 {R,G,B} for the previous cycle's request
- rom_addr, output, 14: image ROM address, row-major, 0..IMG_W*IMG_H-1
- rom_q, input, 24: ROM data, valid 1 cycle after rom_addr

## Operation
Request decode (combinational, cycle t):
- valid = (pixel_ypos != 0)
- row = pixel_ypos - 1 (0-based line)
- in_img = valid && img_x <= pixel_xpos < img_x+IMG_W && img_y <= row < img_y+IMG_H
- When in_img: rom_addr = (row-img_y)*IMG_W + (pixel_xpos-img_x).
- When not in_img: rom_addr holds its last value.
- bar = pixel_xpos / BAR_W, clamped to 7.

Output select (cycle t+1), using valid_d, in_img_d and bar_d registered at t:
- !valid_d: pixel_data = 24'h000000
- in_img_d: pixel_data = rom_q
- otherwise pixel_data = bar colour:
  - 0: FFFFFF
  - 1: 000000
  - 2: FF0000
  - 3: 00FF00
  - 4: 0000FF
  - 5: FFFF00
  - 6: 00FFFF
  - 7: FF00FF

Motion state:
- Registers: img_x (11 b, range 0..H_DISP-IMG_W), img_y (11 b, range 0..V_DISP-IMG_H), dir_x (0 = right), dir_y (0 = down).
- frame_end = (pixel_xpos == H_DISP-1 && pixel_ypos == V_DISP). This is the last request of the frame and occurs exactly once per frame.
- On frame_end with move_en = 1, each axis updates independently:
  - Forward: if pos+STEP >= MAX, then pos <= MAX and dir flips; else pos <= pos+STEP.
  - Backward: if pos <= STEP, then pos <= 0 and dir flips; else pos <= pos-STEP.
  - MAX = H_DISP-IMG_W = 1180 for x; V_DISP-IMG_H = 924 for y.
- On frame_end with move_en = 0: no change to position or direction.
- Position and direction change only at frame_end, so the image never tears within a frame.

Width rules:
- Comparisons are done at ≥12 bits so that img_x+IMG_W never overflows.
- The rom_addr product fits in 14 bits (max 9999).

## Timing
- Latency is exactly 1 vga_clk from pixel_xpos/ypos to pixel_data. This matches the driver presenting coordinates one cycle before its display enable.
- ROM timing: rom_addr is presented at t; rom_q is sampled as pixel_data at t+1. No extra pipeline stage is allowed.
- Reset values (asynchronous, while sys_rst = 1):
  - pixel_data = 0, rom_addr = 0
  - valid_d = 0, in_img_d = 0, bar_d = 0
  - img_x = 0, img_y = 0, dir_x = 0, dir_y = 0
- First request after reset release is decoded normally.
- Reset asserted mid-frame forces all of the above immediately. Motion restarts from (0,0) heading right/down at the next frame_end after release.
- A position update at frame_end takes effect for the next request cycle. That cycle is blanking, so visible content is unaffected.
- Corner hit (both axes reach a limit on the same frame_end): both directions flip in the same cycle.
- move_en changing mid-frame is sampled only at frame_end.

## Test plan
- Reset, then release, frame 1 at (xpos=0, ypos=1):
  - Required: rom_addr = 0; next cycle pixel_data = rom_q.
  - Required at (99,100): rom_addr = 9999.
- Background bars, frame 1:
  - (100,1) → FFFFFF
  - (200,500) → 000000
  - (1279,1024) → FF00FF
  - Each value appears one cycle after the request.
- Blanking: pixel_ypos = 0, pixel_xpos = 0 → pixel_data = 000000 next cycle; rom_addr unchanged.
- Motion, move_en = 1, frame_end pulses only:
  - After 1 frame: img = (4,4).
  - After 231 frames: img_y = 924, dir_y flipped.
  - After 232 frames: img_y = 920.
  - After 295 frames: img_x = 1180, dir_x flipped.
  - Check in each case by probing rom_addr = 0 at the new top-left pixel.
- Freeze: move_en = 0 across 3 frame_ends → position unchanged. Toggle move_en high mid-frame → movement resumes at the next frame_end only.
- Reset mid-frame with image at (400,300) → all outputs and motion state return to reset values asynchronously. The next frame shows the image at (0,0).
